// File: rtl/codec_cfg_seq.sv
// Walks a flattened {addr,data} table into an I2C write engine after a power-up settle, retrying
// NACKed or timed-out writes; also produces the free-running codec master clock XCK.
module codec_cfg_seq #(
  parameter int N_REGS      = 10,
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 8,
  parameter int MAX_RETRY   = 3,
  parameter int TIMEOUT_CYC = 100000,
  parameter int SETTLE_CYC  = 1000,
  parameter int XCK_DIV     = 4
) (
  input  logic                                           CLK_50M,
  input  logic                                           RSTn,
  input  logic                                           start,
  input  logic [N_REGS*(ADDR_W+DATA_W)-1:0]              cfg_table,
  output logic                                           wr_req,
  output logic [ADDR_W-1:0]                              wr_addr,
  output logic [DATA_W-1:0]                              wr_data,
  input  logic                                           wr_done,
  input  logic                                           wr_nack,
  output logic                                           busy,
  output logic                                           cfg_done,
  output logic                                           cfg_err,
  output logic [((N_REGS > 1) ? $clog2(N_REGS) : 1)-1:0] err_index,
  output logic                                           XCK
);
  localparam int ENTRY_W  = ADDR_W + DATA_W;
  localparam int IDX_W    = (N_REGS > 1) ? $clog2(N_REGS) : 1;
  localparam int RTY_W    = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam int TMO_W    = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam int SET_W    = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam int XCK_HALF = XCK_DIV / 2;
  localparam int XCK_W    = (XCK_HALF > 1) ? $clog2(XCK_HALF) : 1;

  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_REGS - 1);
  localparam logic [RTY_W-1:0] RTY_MAX  = RTY_W'(MAX_RETRY);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);
  // The ISSUE cycle closes the settle window, so wr_req shows SETTLE_CYC edges after reset release.
  localparam logic [SET_W-1:0] SET_LAST = SET_W'((SETTLE_CYC > 1) ? SETTLE_CYC - 2 : 0);
  localparam logic [XCK_W-1:0] XCK_LAST = XCK_W'(XCK_HALF - 1);

  typedef enum logic [2:0] {IDLE, SETTLE, ISSUE, WAIT, NEXT, DONE, ERR} state_t;

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [RTY_W-1:0]    retry_q, retry_d;
  logic [TMO_W-1:0]    tmo_q, tmo_d;
  logic [SET_W-1:0]    settle_q, settle_d;
  logic                wr_req_q, wr_req_d;
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0]   wr_data_q, wr_data_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic [IDX_W-1:0]    eidx_q, eidx_d;
  logic                busy_q, busy_d;
  logic                fail;
  logic [ENTRY_W-1:0]  entry;
  logic [XCK_W-1:0]    xck_cnt_q;
  logic                xck_q;

  assign entry = cfg_table[ENTRY_W*int'(idx_q) +: ENTRY_W];

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    retry_d   = retry_q;
    tmo_d     = tmo_q;
    settle_d  = settle_q;
    wr_req_d  = wr_req_q;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    done_d    = done_q;
    err_d     = err_q;
    eidx_d    = eidx_q;
    fail      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = ISSUE;
          idx_d   = '0;
          retry_d = '0;
          done_d  = 1'b0;
          err_d   = 1'b0;
          eidx_d  = '0;
        end
      end
      SETTLE: begin
        if (settle_q == SET_LAST) begin
          state_d = ISSUE;
          idx_d   = '0;
          retry_d = '0;
        end else begin
          settle_d = settle_q + 1'b1;
        end
      end
      ISSUE: begin
        wr_addr_d = entry[ENTRY_W-1 -: ADDR_W];
        wr_data_d = entry[DATA_W-1:0];
        wr_req_d  = 1'b1;
        tmo_d     = '0;
        state_d   = WAIT;
      end
      WAIT: begin
        if (wr_done) begin
          wr_req_d = 1'b0;
          if (wr_nack) begin
            fail = 1'b1;
          end else begin
            retry_d = '0;
            state_d = NEXT;
          end
        end else if (tmo_q == TMO_LAST) begin
          wr_req_d = 1'b0;
          fail     = 1'b1;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
        // Retries pass back through ISSUE, which keeps wr_req low for one cycle.
        if (fail) begin
          if (retry_q < RTY_MAX) begin
            retry_d = retry_q + 1'b1;
            state_d = ISSUE;
          end else begin
            state_d = ERR;
          end
        end
      end
      NEXT: begin
        if (idx_q == IDX_LAST) begin
          state_d = DONE;
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = ISSUE;
        end
      end
      DONE: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
      ERR: begin
        err_d   = 1'b1;
        eidx_d  = idx_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d inside {SETTLE, ISSUE, WAIT, NEXT});
  end

  // Reset parks the FSM in SETTLE with busy low; the first edge after release starts the settle.
  always_ff @(posedge CLK_50M or negedge RSTn) begin
    if (!RSTn) begin
      state_q   <= SETTLE;
      idx_q     <= '0;
      retry_q   <= '0;
      tmo_q     <= '0;
      settle_q  <= '0;
      wr_req_q  <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      eidx_q    <= '0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      retry_q   <= retry_d;
      tmo_q     <= tmo_d;
      settle_q  <= settle_d;
      wr_req_q  <= wr_req_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      done_q    <= done_d;
      err_q     <= err_d;
      eidx_q    <= eidx_d;
      busy_q    <= busy_d;
    end
  end

  always_ff @(posedge CLK_50M or negedge RSTn) begin
    if (!RSTn) begin
      xck_cnt_q <= '0;
      xck_q     <= 1'b0;
    end else if (xck_cnt_q == XCK_LAST) begin
      xck_cnt_q <= '0;
      xck_q     <= ~xck_q;
    end else begin
      xck_cnt_q <= xck_cnt_q + 1'b1;
    end
  end

  assign wr_req    = wr_req_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign busy      = busy_q;
  assign cfg_done  = done_q;
  assign cfg_err   = err_q;
  assign err_index = eidx_q;
  assign XCK       = xck_q;

endmodule

// File: doc/codec_cfg_seq.md
CODEC_CFG_SEQ -- requirements
Module: codec_cfg_seq

Interface
REQ-001 The block SHALL take these parameters:
- N_REGS, 10, number of table entries.
- ADDR_W, 8, register address width.
- DATA_W, 8, register data width.
- MAX_RETRY, 3, retries per entry after a NACK or timeout.
- TIMEOUT_CYC, 100000, maximum wait cycles for wr_done.
- SETTLE_CYC, 1000, delay cycles after reset before the first write.
- XCK_DIV, 4, master-clock divide ratio; even and at least 2.
REQ-002 The block SHALL have these ports:
- CLK_50M  in  1  system clock.
- RSTn  in  1  reset; asynchronous, active-low.
- start  in  1  one-cycle pulse that re-runs the whole table.
- cfg_table  in  N_REGS*(ADDR_W+DATA_W)  flattened table; entry i sits at bits [(i+1)*W-1 : i*W] with W = ADDR_W+DATA_W; address in the upper ADDR_W bits.
- wr_req  out  1  write request to the I2C write engine.
- wr_addr  out  ADDR_W  register address for the current write.
- wr_data  out  DATA_W  register data for the current write.
- wr_done  in  1  one-cycle pulse: engine finished the transfer.
- wr_nack  in  1  qualified by wr_done; 1 means the slave did not acknowledge.
- busy  out  1  sequence in progress.
- cfg_done  out  1  all entries written successfully; sticky.
- cfg_err  out  1  entry failed after all retries; sticky.
- err_index  out  clog2(N_REGS)  index of the failed entry.
- XCK  out  1  codec master clock.

Function
REQ-003 FSM states SHALL be IDLE, SETTLE, ISSUE, WAIT, NEXT, DONE, ERR.
REQ-004 After reset is released, the FSM SHALL enter SETTLE and remain there exactly SETTLE_CYC cycles, then enter ISSUE with index 0.
REQ-005 In ISSUE, the block SHALL drive wr_addr and wr_data from entry[index], assert wr_req, and enter WAIT on the next cycle.
REQ-006 wr_req SHALL stay high from ISSUE through WAIT until the cycle wr_done is sampled, and SHALL be low on the following cycle.
REQ-007 wr_addr and wr_data SHALL be stable throughout a request.
REQ-008 On wr_done with wr_nack=0, the FSM SHALL go to NEXT and clear the retry count.
REQ-009 In NEXT, if index = N_REGS-1 the FSM SHALL go to DONE; otherwise it SHALL increment index and go to ISSUE.
- Minimum gap between consecutive wr_req assertions: 2 cycles low.
REQ-010 wr_done with wr_nack=1, or TIMEOUT_CYC cycles in WAIT without wr_done, SHALL count as a failure.
- If retry count < MAX_RETRY: increment the count and return to ISSUE with the same index.
- Otherwise: go to ERR.
REQ-011 On a timeout, wr_req SHALL drop for at least 1 cycle before it is re-asserted.
REQ-012 DONE SHALL set cfg_done=1 and ERR SHALL set cfg_err=1 and latch err_index; both states SHALL then fall to IDLE.
REQ-013 busy SHALL be 1 in SETTLE, ISSUE, WAIT and NEXT, and 0 otherwise.
REQ-014 A start pulse in IDLE SHALL clear cfg_done, cfg_err and err_index and enter ISSUE with index 0, without SETTLE.
- A start pulse while busy=1 SHALL be ignored.
REQ-015 A wr_done pulse outside WAIT SHALL be ignored.
REQ-016 cfg_table SHALL be sampled per entry at ISSUE.
- The table may change between runs.
- A change mid-run affects only entries not yet issued.
REQ-017 For an N_REGS=1 table, the FSM SHALL reach DONE after a single successful write.
REQ-018 XCK SHALL toggle every XCK_DIV/2 clock cycles, giving a 50% duty cycle.
- Default: 12.5 MHz.
- XCK is free-running and independent of the FSM.
REQ-019 The retry counter, timeout counter and settle counter SHALL be sized from their parameters with clog2, and SHALL NOT wrap.

Reset
REQ-020 Asserting RSTn low SHALL immediately force all of the following, including mid-transfer:
- FSM = SETTLE-pending.
- wr_req=0, wr_addr=0, wr_data=0.
- busy=0, cfg_done=0, cfg_err=0, err_index=0.
- XCK=0.
- All counters = 0.
REQ-021 The first busy=1 cycle SHALL be the first clock edge after RSTn deasserts.
REQ-022 A partially issued sequence SHALL NOT resume after reset.

Verification
REQ-023 Default parameters; engine model that acks every write 5 cycles after wr_req.
- Required: 10 requests in index order, addresses 00,02,...,12; first wr_req exactly 1000 cycles after reset release; cfg_done=1, busy=0.
REQ-024 NACK on entry 3 twice, then ack.
- Required: entry 3 issued 3 times with identical addr/data; run completes with cfg_done=1, cfg_err=0.
REQ-025 NACK on entry 5 every time.
- Required: 4 attempts total; cfg_err=1, err_index=5, cfg_done=0; no request for entry 6.
REQ-026 Engine never responds, TIMEOUT_CYC=50.
- Required: wr_req drops after 50 cycles, 3 retries, then cfg_err=1, err_index=0.
REQ-027 After cfg_done, pulse start, and pulse start again during the run.
- Required: table re-issued from index 0 with no settle delay; the second pulse has no effect; exactly 10 writes.
REQ-028 Assert RSTn during WAIT of entry 4, release after 3 cycles.
- Required: wr_req=0 immediately; after release, 1000-cycle settle, then writes restart at index 0.
- XCK, throughout: period 4 cycles, high 2 cycles.
